fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  IF stage: holds the PC, fetches instructions from the instruction memory port with a
//  req/ready + valid handshake, and presents instr/pc/pc+4 to decode_stage's pipeline regs.
//  Handles decode stall and EX branch/jump redirect. When no instruction is ready it drives NOP.
// PARAMETERS
//  XLEN      32            data/address width
//  ILEN      32            instruction width
//  RESET_PC  32'h0000_1000 PC after reset
//  NOP       32'h0000_0013 bubble instruction (addi x0,x0,0)
// PORTS
//  clk            in   1     clock, all state on rising edge
//  reset          in   1     synchronous, active-low; state resets when reset==0 at a clk edge
//  stall_in       in   1     decode stalled; current instr_out not consumed this cycle
//  pc_src_in      in   1     EX redirect (taken branch/jump); has priority over stall_in
//  pc_target_in   in   XLEN  redirect target
//  imem_req_out   out  1     fetch request
//  imem_addr_out  out  XLEN  request address (= pc_q)
//  imem_ready_in  in   1     imem accepts request this cycle
//  imem_valid_in  in   1     response valid, 1 cycle pulse
//  imem_data_in   in   ILEN  response instruction
//  instr_out      out  ILEN  instruction to decode (NOP when instr_valid_out==0)
//  pc_out         out  XLEN  PC of instr_out
//  pc_plus4_out   out  XLEN  pc_out + 4, modulo 2^XLEN
//  instr_valid_out out 1     buffer holds a real instruction
// BEHAVIOUR
//  - State: pc_q, buf_q, st in {REQ, WAIT, HOLD, DRAIN}; at most one request outstanding.
//  - Reset: st=REQ, pc_q=RESET_PC, buf_q=NOP. Outputs: instr_valid_out=0, instr_out=NOP,
//    pc_out=RESET_PC, pc_plus4_out=RESET_PC+4, imem_req_out=1, imem_addr_out=RESET_PC.
//    imem shares the same reset, so no response survives reset; reset mid-WAIT drops it.
//  - REQ: imem_req_out=1, addr=pc_q. ready=1 -> WAIT. ready=0 -> stay REQ. imem_valid_in ignored.
//  - WAIT: imem_req_out=0. valid=1 -> buf_q<=imem_data_in, HOLD.
//  - HOLD: instr_valid_out=1, instr_out=buf_q. stall_in=0 -> consumed: pc_q<=pc_q+4, REQ.
//    stall_in=1 -> stay HOLD, outputs stable.
//  - DRAIN: wait for the stale response. valid=1 -> discard it, REQ.
//  - pc_out=pc_q in all states, so in HOLD it is the PC of buf_q.
//  - Redirect (pc_src_in=1) overrides the above in any state, regardless of stall_in:
//    pc_q<=pc_target_in, buffer invalidated.
//    REQ & ready=1 -> DRAIN (request already accepted at old address).
//    REQ & ready=0 -> REQ (address may change while unaccepted).
//    WAIT & valid=0 -> DRAIN.  WAIT & valid=1 -> REQ (response dropped).
//    HOLD -> REQ.  DRAIN -> DRAIN, or REQ if valid=1 that cycle.
//  - Best-case throughput: 1 instr per 3 cycles (REQ->WAIT->HOLD) with 1-cycle imem latency.
//  - Redirect target alignment is not checked; low 2 bits pass to imem_addr_out.
// TESTING
//  1 reset=0 for 2 cycles, then 1 -> imem_addr_out=0x1000 with req=1; instr_valid_out=0, instr_out=0x13.
//  2 imem 1-cycle latency returning 0x00500093, stall_in=0 -> instr_out=0x00500093, pc_out=0x1000,
//    pc_plus4_out=0x1004 for 1 cycle, then next request at 0x1004.
//  3 stall_in=1 for 4 cycles in HOLD -> outputs stable; after release, next req at pc+4.
//  4 pc_src_in=1, target=0x2000 in the cycle req is accepted at 0x1008 -> stale response discarded;
//    next req=0x2000; delivered instr has pc_out=0x2000.
//  5 pc_src_in=1 with stall_in=1 in HOLD -> buffer invalidated, NOP out, req at target next cycle.
//  6 pc_q=0xFFFF_FFFC delivered -> pc_plus4_out=0x0; next req address 0x0.

Source files
------------

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, runs a single-outstanding imem request handshake
// and holds the fetched instruction for decode, honouring stall and redirect.
module fetch_stage #(
    parameter int          XLEN     = 32,
    parameter int          ILEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_1000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_in,
    input  logic            pc_src_in,
    input  logic [XLEN-1:0] pc_target_in,
    output logic            imem_req_out,
    output logic [XLEN-1:0] imem_addr_out,
    input  logic            imem_ready_in,
    input  logic            imem_valid_in,
    input  logic [ILEN-1:0] imem_data_in,
    output logic [ILEN-1:0] instr_out,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_plus4_out,
    output logic            instr_valid_out
);

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [XLEN-1:0] PC_INIT = XLEN'(RESET_PC);
    localparam logic [ILEN-1:0] BUBBLE  = ILEN'(NOP);
    localparam logic [XLEN-1:0] STEP    = XLEN'(4);

    state_t          st;
    logic [XLEN-1:0] pc_q;
    logic [ILEN-1:0] buf_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            st    <= REQ;
            pc_q  <= PC_INIT;
            buf_q <= BUBBLE;
        end else if (pc_src_in) begin
            // A response already in flight belongs to the old path: drain it.
            pc_q  <= pc_target_in;
            buf_q <= BUBBLE;
            unique case (st)
                REQ:     st <= imem_ready_in ? DRAIN : REQ;
                WAIT:    st <= imem_valid_in ? REQ : DRAIN;
                HOLD:    st <= REQ;
                DRAIN:   st <= imem_valid_in ? REQ : DRAIN;
                default: st <= REQ;
            endcase
        end else begin
            unique case (st)
                REQ: begin
                    if (imem_ready_in) st <= WAIT;
                end
                WAIT: begin
                    if (imem_valid_in) begin
                        buf_q <= imem_data_in;
                        st    <= HOLD;
                    end
                end
                HOLD: begin
                    if (!stall_in) begin
                        pc_q <= pc_q + STEP;
                        st   <= REQ;
                    end
                end
                DRAIN: begin
                    if (imem_valid_in) st <= REQ;
                end
                default: st <= REQ;
            endcase
        end
    end

    assign imem_req_out    = (st == REQ);
    assign imem_addr_out   = pc_q;
    assign instr_valid_out = (st == HOLD);
    assign instr_out       = (st == HOLD) ? buf_q : BUBBLE;
    assign pc_out          = pc_q;
    assign pc_plus4_out    = pc_q + STEP;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed stimulus, imem responder stub and an
// abstract pending/holding model checked on every cycle.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_1000;
    localparam logic [31:0] NOPI   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_in, pc_src_in;
    logic [31:0] pc_target_in;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic        imem_ready_in, imem_valid_in;
    logic [31:0] imem_data_in;
    logic [31:0] instr_out, pc_out, pc_plus4_out;
    logic        instr_valid_out;

    fetch_stage dut (
        .clk(clk), .reset(reset),
        .stall_in(stall_in), .pc_src_in(pc_src_in),
        .pc_target_in(pc_target_in),
        .imem_req_out(imem_req_out), .imem_addr_out(imem_addr_out),
        .imem_ready_in(imem_ready_in), .imem_valid_in(imem_valid_in),
        .imem_data_in(imem_data_in),
        .instr_out(instr_out), .pc_out(pc_out),
        .pc_plus4_out(pc_plus4_out),
        .instr_valid_out(instr_valid_out)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 0;

    // Abstract model: is a request outstanding, is it stale, is an instr held.
    logic [31:0] m_pc, m_buf;
    bit          m_out, m_disc, m_have;

    // imem responder stub
    bit          pend;
    logic [31:0] pend_addr;
    int          cnt;
    int          lat = 1;

    function automatic logic [31:0] word(input logic [31:0] a);
        return (a == RST_PC) ? 32'h0050_0093 : (a ^ 32'h5A00_0003);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("req", 32'(imem_req_out), 32'(!m_out && !m_have));
            chk("addr", imem_addr_out, m_pc);
            chk("valid", 32'(instr_valid_out), 32'(m_have));
            chk("instr", instr_out, m_have ? m_buf : NOPI);
            chk("pc", pc_out, m_pc);
            chk("pc4", pc_plus4_out, m_pc + 32'd4);
        end
    end

    task automatic model_step();
        bit acc, rsp;
        if (!reset) begin
            m_pc = RST_PC; m_buf = NOPI;
            m_out = 0; m_disc = 0; m_have = 0;
        end else begin
            acc = !m_out && !m_have && imem_ready_in;
            rsp = m_out && imem_valid_in;
            if (pc_src_in) begin
                m_pc   = pc_target_in;
                m_have = 0;
                m_out  = acc || (m_out && !imem_valid_in);
                m_disc = m_out;
            end else if (acc) begin
                m_out = 1; m_disc = 0;
            end else if (rsp) begin
                m_out = 0;
                if (!m_disc) begin
                    m_have = 1; m_buf = imem_data_in;
                end
                m_disc = 0;
            end else if (m_have && !stall_in) begin
                m_have = 0; m_pc = m_pc + 32'd4;
            end
        end
    endtask

    // One cycle: drive inputs after negedge, clock, return at next negedge.
    task automatic tick(input bit st, input bit src,
                        input logic [31:0] tgt, input bit rdy);
        bit acc;
        logic [31:0] aa;
        stall_in = st; pc_src_in = src;
        pc_target_in = tgt; imem_ready_in = rdy;
        imem_valid_in = pend && (cnt == 0);
        imem_data_in = imem_valid_in ? word(pend_addr) : 32'hDEAD_BEEF;
        #1;
        acc = imem_req_out && imem_ready_in;
        aa  = imem_addr_out;
        @(posedge clk);
        model_step();
        if (!reset) pend = 0;
        else begin
            if (imem_valid_in) pend = 0;
            else if (pend) cnt--;
            if (acc) begin
                pend = 1; pend_addr = aa; cnt = lat - 1;
            end
        end
        chk_en = 1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0);
    endtask

    initial begin
        reset = 0; pend = 0; cnt = 0; pend_addr = 0;
        stall_in = 0; pc_src_in = 0; pc_target_in = 0;
        imem_ready_in = 0; imem_valid_in = 0; imem_data_in = 0;
        @(negedge clk);
        // 1: reset
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 1);
        reset = 1;
        chk("t1 addr", imem_addr_out, 32'h1000);
        chk("t1 req", 32'(imem_req_out), 32'd1);
        chk("t1 valid", 32'(instr_valid_out), 32'd0);
        chk("t1 instr", instr_out, 32'h13);
        // 2: basic fetch
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 0);
        chk("t2 instr", instr_out, 32'h0050_0093);
        chk("t2 pc", pc_out, 32'h1000);
        chk("t2 pc4", pc_plus4_out, 32'h1004);
        tick(0, 0, 0, 0);
        chk("t2 next", imem_addr_out, 32'h1004);
        chk("t2 nvld", 32'(instr_valid_out), 32'd0);
        // 3: stall in HOLD
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick(1, 0, 0, 0);
            chk("t3 instr", instr_out, 32'h5A00_1007);
            chk("t3 pc", pc_out, 32'h1004);
        end
        tick(0, 0, 0, 0);
        chk("t3 next", imem_addr_out, 32'h1008);
        // 4: redirect as request accepted
        tick(0, 1, 32'h2000, 1);
        chk("t4 drain", 32'(imem_req_out), 32'd0);
        tick(0, 0, 0, 0);
        chk("t4 addr", imem_addr_out, 32'h2000);
        chk("t4 nvld", 32'(instr_valid_out), 32'd0);
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 0);
        chk("t4 pc", pc_out, 32'h2000);
        chk("t4 instr", instr_out, 32'h5A00_2003);
        // 5: redirect beats stall in HOLD
        tick(1, 1, 32'h3000, 0);
        chk("t5 valid", 32'(instr_valid_out), 32'd0);
        chk("t5 instr", instr_out, 32'h13);
        chk("t5 addr", imem_addr_out, 32'h3000);
        chk("t5 req", 32'(imem_req_out), 32'd1);
        // 6: PC wrap
        tick(0, 1, 32'hFFFF_FFFC, 0);
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 0);
        chk("t6 pc", pc_out, 32'hFFFF_FFFC);
        chk("t6 pc4", pc_plus4_out, 32'h0);
        tick(0, 0, 0, 0);
        chk("t6 next", imem_addr_out, 32'h0);
        // longer latency, redirect in WAIT with and without response
        lat = 3;
        idle(2);
        tick(0, 0, 0, 1);
        tick(0, 1, 32'h4000, 0);
        idle(3);
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 0);
        tick(0, 1, 32'h5000, 0);
        idle(2);
        tick(0, 0, 0, 1);
        idle(4);
        // reset mid-WAIT drops the response
        tick(0, 0, 0, 1);
        reset = 0;
        tick(0, 0, 0, 0);
        reset = 1;
        chk("rst addr", imem_addr_out, 32'h1000);
        idle(3);
        // mixed traffic
        for (int i = 0; i < 300; i++) begin
            lat = 1 + int'($urandom_range(2));
            tick(1'($urandom_range(1)), ($urandom_range(9) == 0),
                 $urandom & 32'hFFFF_FFFC, 1'($urandom_range(1)));
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
